// File: rtl/rv_wb_pkg.sv
// rv_wb_pkg: shared widths and the write-back request type for the write-back block
// Contents: XLEN, NREG, REG_ADDR_W and wb_req_t {we, rd, data}
package rv_wb_pkg;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order buffer of LSU/MUL write-back requests
// Ports: clk, rst (sync, active-high); push_i/din_i enqueue when not full;
//        pop_i dequeues when not empty; dout_o is the head entry;
//        full_o/empty_o/count_o are decoded from the registered count.
module wb_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  wb_req_t       din_i,
    input  logic          pop_i,
    output wb_req_t       dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    wb_req_t       mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    // Full/empty come from pre-edge state, so a push and a pop in the same edge both use the old count.
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= do_push ? wr_q + AW'(1) : wr_q;
            rd_q  <= do_pop ? rd_q + AW'(1) : rd_q;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/wb_write_ctrl.sv
// wb_write_ctrl: register-file write port owner merging ALU and buffered LSU/MUL results, plus busy scoreboard
// Ports: clk, rst (sync, active-high)
//        alu_valid/alu_rd/alu_data      single-cycle results, highest priority, never stalled
//        issue_valid/issue_rd           long-latency issue, marks rd busy
//        lsu_valid/lsu_ready/lsu_rd/lsu_data  long-latency results into the FIFO
//        busy_vec                       pending-write scoreboard (bit 0 always 0)
//        fifo_full                      stall request for new long-latency issue
//        reg_write/rd_addr/wb_data      registered register-file write port
module wb_write_ctrl
    import rv_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic [NREG-1:0]       busy_vec,
    output logic                  fifo_full,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       wb_data
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    wb_req_t       head, wp_q, wp_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;

    assign lsu_ready = count != CW'(FIFO_DEPTH);
    assign fifo_full = full;
    assign push      = lsu_valid && lsu_ready;
    // ALU owns the port whenever it has a result; the FIFO drains only in ALU bubbles.
    assign pop       = !alu_valid && !empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .din_i  (wb_req_t'{we: 1'b1, rd: lsu_rd, data: lsu_data}),
        .pop_i  (pop),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty),
        .count_o(count)
    );

    // x0 writes are still consumed but never enable the register file.
    always_comb begin
        wp_d = alu_valid ? wb_req_t'{we: alu_rd != '0, rd: alu_rd, data: alu_data}
             : pop       ? wb_req_t'{we: head.we && head.rd != '0, rd: head.rd, data: head.data}
             :             wb_req_t'{we: 1'b0, rd: wp_q.rd, data: wp_q.data};
    end

    // Clear first, then set, so a same-edge re-issue of the popped register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (pop) busy_d[head.rd] = 1'b0;
        if (issue_valid) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q   <= '0;
            busy_q <= '0;
        end else begin
            wp_q   <= wp_d;
            busy_q <= busy_d;
        end
    end

    assign reg_write = wp_q.we;
    assign rd_addr   = wp_q.rd;
    assign wb_data   = wp_q.data;
    assign busy_vec  = busy_q;

    // Issuing to a register that is still pending (and not retiring this edge) is an ID-stage bug.
    assert property (@(posedge clk) disable iff (rst)
        !(issue_valid && issue_rd != '0 && busy_q[issue_rd] && !(pop && head.rd == issue_rd)));
endmodule

// File: tb/tb_wb_write_ctrl.sv
// tb_wb_write_ctrl: directed self-checking bench for wb_write_ctrl with a write scoreboard
module tb_wb_write_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, issue_valid = 1'b0, lsu_valid = 1'b0;
    logic [4:0]  alu_rd = '0, issue_rd = '0, lsu_rd = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        lsu_ready, fifo_full, reg_write;
    logic [31:0] busy_vec;
    logic [4:0]  rd_addr;
    logic [31:0] wb_data;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_write_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .busy_vec   (busy_vec),
        .fifo_full  (fifo_full),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .wb_data    (wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        q.push_back('{rd: rd, d: d});
    endtask

    // Every enabled write must match the next expected write in order.
    always @(negedge clk) begin
        if (reg_write) begin
            if (q.size() == 0) chk("unexpected_write", {27'd0, rd_addr}, 32'hFFFF_FFFF);
            else begin
                e = q.pop_front();
                chk("sb_rd", {27'd0, rd_addr}, {27'd0, e.rd});
                chk("sb_data", wb_data, e.d);
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_we", {31'd0, reg_write}, 32'd0);
        chk("rst_rd", {27'd0, rd_addr}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);

        // Fill FIFO with 2 entries under ALU traffic, then reset mid-operation
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11; expect_wr(1, 32'h11);
        issue_valid = 1; issue_rd = 10; lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hAA;
        tick();
        alu_rd = 2; alu_data = 32'h22; expect_wr(2, 32'h22);
        issue_rd = 11; lsu_rd = 11; lsu_data = 32'hBB;
        tick();
        alu_valid = 0; issue_valid = 0; lsu_valid = 0;
        chk("fill_full", {31'd0, fifo_full}, 32'd1);
        chk("fill_ready", {31'd0, lsu_ready}, 32'd0);
        chk("fill_busy", busy_vec, 32'h0000_0C00);
        rst = 1;
        tick();
        chk("rst_mid_we", {31'd0, reg_write}, 32'd0);
        tick();
        rst = 0;
        chk("rst2_busy", busy_vec, 32'd0);
        chk("rst2_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst2_full", {31'd0, fifo_full}, 32'd0);
        tick();
        chk("rst2_drained", {31'd0, reg_write}, 32'd0);

        // ALU only, including an x0 write and hold on idle
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; expect_wr(5, 32'hDEADBEEF);
        tick();
        chk("alu_we", {31'd0, reg_write}, 32'd1);
        chk("alu_rd", {27'd0, rd_addr}, 32'd5);
        chk("alu_data", wb_data, 32'hDEADBEEF);
        alu_rd = 0; alu_data = 32'h55;
        tick();
        alu_valid = 0;
        chk("alu_x0_we", {31'd0, reg_write}, 32'd0);
        tick();
        chk("idle_we", {31'd0, reg_write}, 32'd0);
        chk("idle_hold_data", wb_data, 32'h55);

        // LSU path with scoreboard
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        chk("lsu_busy_set", busy_vec, 32'h0000_0080);
        tick();
        tick();
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234; expect_wr(7, 32'h1234);
        tick();
        lsu_valid = 0;
        chk("lsu_nobypass", {31'd0, reg_write}, 32'd0);
        chk("lsu_busy_hold", busy_vec, 32'h0000_0080);
        tick();
        chk("lsu_we", {31'd0, reg_write}, 32'd1);
        chk("lsu_rd", {27'd0, rd_addr}, 32'd7);
        chk("lsu_busy_clr", busy_vec, 32'd0);

        // ALU and LSU push on the same edge
        alu_valid = 1; alu_rd = 3; alu_data = 32'h333; expect_wr(3, 32'h333);
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h999; expect_wr(9, 32'h999);
        tick();
        alu_valid = 0; lsu_valid = 0;
        chk("conf_first", {27'd0, rd_addr}, 32'd3);
        tick();
        chk("conf_second", {27'd0, rd_addr}, 32'd9);
        chk("conf_we", {31'd0, reg_write}, 32'd1);
        tick();

        // Back-pressure under sustained ALU traffic
        alu_valid = 1; alu_rd = 20; alu_data = 32'h20; expect_wr(20, 32'h20);
        lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hC12;
        issue_valid = 1; issue_rd = 12;
        tick();
        alu_rd = 21; alu_data = 32'h21; expect_wr(21, 32'h21);
        lsu_rd = 13; lsu_data = 32'hC13; issue_rd = 13;
        tick();
        chk("bp_ready0", {31'd0, lsu_ready}, 32'd0);
        chk("bp_full", {31'd0, fifo_full}, 32'd1);
        chk("bp_busy", busy_vec, 32'h0000_3000);
        issue_valid = 0;
        alu_rd = 22; alu_data = 32'h22; expect_wr(22, 32'h22);
        lsu_rd = 14; lsu_data = 32'hC14;
        tick();
        alu_rd = 23; alu_data = 32'h23; expect_wr(23, 32'h23);
        expect_wr(12, 32'hC12);
        expect_wr(13, 32'hC13);
        tick();
        chk("bp_ready_still0", {31'd0, lsu_ready}, 32'd0);
        alu_valid = 0;
        tick();
        chk("bp_pop12", {27'd0, rd_addr}, 32'd12);
        chk("bp_ready1", {31'd0, lsu_ready}, 32'd1);
        expect_wr(14, 32'hC14);
        tick();
        lsu_valid = 0;
        chk("bp_pop13", {27'd0, rd_addr}, 32'd13);
        chk("bp_busy_clr", busy_vec, 32'd0);
        tick();
        chk("bp_pop14", {27'd0, rd_addr}, 32'd14);
        chk("bp_notfull", {31'd0, fifo_full}, 32'd0);
        tick();

        // Set and clear of the same register on one edge
        issue_valid = 1; issue_rd = 4;
        tick();
        issue_valid = 0;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44; expect_wr(4, 32'h44);
        tick();
        lsu_valid = 0;
        issue_valid = 1; issue_rd = 4;
        tick();
        issue_valid = 0;
        chk("col_busy", busy_vec, 32'h0000_0010);
        chk("col_rd", {27'd0, rd_addr}, 32'd4);
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h45; expect_wr(4, 32'h45);
        tick();
        lsu_valid = 0;
        tick();
        chk("col_busy_clr", busy_vec, 32'd0);
        tick();
        tick();
        chk("sb_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
